// File: rtl/seq_sum_collector.sv
// Collects a batch of N_RESULTS results from an upstream sequential adder into a
// saturating accumulator and holds the total until a consumer accepts it.
module seq_sum_collector #(
    parameter int N_RESULTS = 10,
    parameter int ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sum,
    input  logic             cr_out,
    input  logic             done,
    input  logic             clr,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [7:0]       count,
    output logic             ovf,
    output logic             drop
);

    // state    | meaning
    // ST_ACCUM | summing results into the batch total
    // ST_HOLD  | batch complete, total presented until accepted
    typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

    localparam logic [7:0] C_N = 8'(N_RESULTS);

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [7:0]       r_count, w_count_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_drop, w_drop_nxt;
    logic             r_done_q;

    logic             w_result;
    logic [ACC_W-1:0] w_operand;
    logic [ACC_W:0]   w_sum;
    logic [7:0]       w_count_inc;

    assign w_result    = done & ~r_done_q;
    assign w_operand   = ACC_W'({cr_out, sum});
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_operand};
    assign w_count_inc = r_count + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_ACCUM;
            r_acc    <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= 1'b0;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_count  <= w_count_nxt;
            r_ovf    <= w_ovf_nxt;
            r_drop   <= w_drop_nxt;
            r_done_q <= done;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_drop_nxt  = r_drop;
        if (clr) begin
            w_state_nxt = ST_ACCUM;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_drop_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_result) begin
                        w_acc_nxt   = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
                        w_ovf_nxt   = r_ovf | w_sum[ACC_W];
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == C_N) w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (acc_ready) begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = '0;
                        w_count_nxt = '0;
                        w_ovf_nxt   = 1'b0;
                        w_drop_nxt  = 1'b0;
                        if (w_result) begin
                            // A single operand cannot exceed the accumulator, so no saturation check here.
                            w_acc_nxt   = w_operand;
                            w_count_nxt = 8'd1;
                            if (C_N == 8'd1) w_state_nxt = ST_HOLD;
                        end
                    end else if (w_result) begin
                        w_drop_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    assign acc_out   = r_acc;
    assign acc_valid = (r_state == ST_HOLD);
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign drop      = r_drop;

endmodule

// File: tb/tb_seq_sum_collector.sv
// Directed bench for seq_sum_collector: default instance (N=10, ACC_W=16) plus
// a narrow instance (N=2, ACC_W=9) for saturation.
module tb_seq_sum_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sum = '0;
    logic        cr_out = 1'b0;
    logic        done = 1'b0;
    logic        clr = 1'b0;
    logic        acc_ready = 1'b0;

    logic [15:0] acc_out;
    logic        acc_valid;
    logic [7:0]  count;
    logic        ovf;
    logic        drop;

    logic [8:0]  acc9_out;
    logic        acc9_valid;
    logic [7:0]  count9;
    logic        ovf9;
    logic        drop9;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_sum_collector #(.N_RESULTS(10), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .sum(sum), .cr_out(cr_out), .done(done), .clr(clr),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .count(count), .ovf(ovf), .drop(drop)
    );

    seq_sum_collector #(.N_RESULTS(2), .ACC_W(9)) dut9 (
        .clk(clk), .rst(rst), .sum(sum), .cr_out(cr_out), .done(done), .clr(clr),
        .acc_out(acc9_out), .acc_valid(acc9_valid), .acc_ready(acc_ready),
        .count(count9), .ovf(ovf9), .drop(drop9)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One-cycle done pulse followed by one low cycle so the next pulse re-arms.
    task automatic send(input logic [8:0] op);
        {cr_out, sum} = op;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_acc",   32'(acc_out),   32'd0);
        chk("rst_valid", 32'(acc_valid), 32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        chk("rst_drop",  32'(drop),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Ten results of 0x1FF: 10 * 511 = 5110.
        for (int i = 0; i < 9; i++) send(9'h1FF);
        chk("b9_count", 32'(count),     32'd9);
        chk("b9_valid", 32'(acc_valid), 32'd0);
        chk("b9_acc",   32'(acc_out),   32'd4599);
        {cr_out, sum} = 9'h1FF;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("b10_valid", 32'(acc_valid), 32'd1);
        chk("b10_acc",   32'(acc_out),   32'd5110);
        chk("b10_count", 32'(count),     32'd10);
        chk("b10_ovf",   32'(ovf),       32'd0);
        repeat (3) @(negedge clk);
        chk("hold_valid", 32'(acc_valid), 32'd1);
        chk("hold_acc",   32'(acc_out),   32'd5110);

        // Result in HOLD without accept is dropped.
        send(9'h005);
        chk("drop_flag",  32'(drop),    32'd1);
        chk("drop_acc",   32'(acc_out), 32'd5110);
        chk("drop_count", 32'(count),   32'd10);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("hs_acc",   32'(acc_out),   32'd0);
        chk("hs_count", 32'(count),     32'd0);
        chk("hs_drop",  32'(drop),      32'd0);
        chk("hs_valid", 32'(acc_valid), 32'd0);

        // acc_ready in ACCUM is ignored.
        acc_ready = 1'b1;
        send(9'h010);
        acc_ready = 1'b0;
        chk("rdy_acc",   32'(acc_out), 32'h10);
        chk("rdy_count", 32'(count),   32'd1);

        // Level held high counts once.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_count", 32'(count),   32'd0);
        chk("clr_acc",   32'(acc_out), 32'd0);
        {cr_out, sum} = 9'h0AB;
        done = 1'b1;
        repeat (20) @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        chk("lvl_count", 32'(count),   32'd1);
        chk("lvl_acc",   32'(acc_out), 32'hAB);

        // Fill to HOLD, force a drop, then accept coincident with a new result.
        for (int i = 0; i < 9; i++) send(9'h001);
        chk("f_valid", 32'(acc_valid), 32'd1);
        chk("f_acc",   32'(acc_out),   32'hB4);
        send(9'h007);
        chk("f_drop", 32'(drop), 32'd1);
        {cr_out, sum} = 9'h023;
        done = 1'b1;
        acc_ready = 1'b1;
        @(negedge clk);
        done = 1'b0;
        acc_ready = 1'b0;
        chk("co_acc",   32'(acc_out),   32'h23);
        chk("co_count", 32'(count),     32'd1);
        chk("co_valid", 32'(acc_valid), 32'd0);
        chk("co_drop",  32'(drop),      32'd0);
        @(negedge clk);

        // clr at count=3 overrides a coincident result; done_q still follows done.
        send(9'h001);
        send(9'h001);
        chk("c3_count", 32'(count), 32'd3);
        {cr_out, sum} = 9'h040;
        done = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr3_count", 32'(count),   32'd0);
        chk("clr3_acc",   32'(acc_out), 32'd0);
        @(negedge clk);
        chk("clr_doneq_count", 32'(count), 32'd0);
        done = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-period at count=5.
        for (int i = 0; i < 5; i++) send(9'h002);
        chk("r5_count", 32'(count),   32'd5);
        chk("r5_acc",   32'(acc_out), 32'd10);
        #2 rst = 1'b0;
        #1;
        chk("arst_acc",   32'(acc_out),   32'd0);
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_valid", 32'(acc_valid), 32'd0);
        chk("arst_ovf",   32'(ovf),       32'd0);
        chk("arst_drop",  32'(drop),      32'd0);
        {cr_out, sum} = 9'h033;
        done = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("pr_count", 32'(count),   32'd1);
        chk("pr_acc",   32'(acc_out), 32'h33);
        repeat (3) @(negedge clk);
        chk("pr_hold_count", 32'(count), 32'd1);
        done = 1'b0;
        @(negedge clk);

        // Narrow instance: 0x1FF + 0x1FF saturates at 0x1FF.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        send(9'h1FF);
        chk("w9_acc1", 32'(acc9_out), 32'h1FF);
        chk("w9_ovf1", 32'(ovf9),     32'd0);
        send(9'h1FF);
        chk("w9_acc",   32'(acc9_out),   32'h1FF);
        chk("w9_ovf",   32'(ovf9),       32'd1);
        chk("w9_valid", 32'(acc9_valid), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("w9_clr_ovf",   32'(ovf9),       32'd0);
        chk("w9_clr_valid", 32'(acc9_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
